// File: rtl/dm_responder_if.sv
// dm_responder_if: M-stage data-memory control/data bundle.
//   master: the pipeline side (drives DMWr/DMIn_BEOp/DMOut_MEOp/addr/din,
//           receives dout/rsp_valid/addr_err/busy).
//   slave : the dm_responder side.
interface dm_responder_if;
  logic        DMWr;
  logic [1:0]  DMIn_BEOp;   // 0 none, 1 SW, 2 SH, 3 SB
  logic [2:0]  DMOut_MEOp;  // 0 none, 1 LW, 2 LH, 3 LHU, 4 LB, 5 LBU
  logic [31:0] addr;
  logic [31:0] din;
  logic [31:0] dout;
  logic        rsp_valid;
  logic        addr_err;
  logic        busy;

  modport master (
    output DMWr, DMIn_BEOp, DMOut_MEOp, addr, din,
    input  dout, rsp_valid, addr_err, busy
  );

  modport slave (
    input  DMWr, DMIn_BEOp, DMOut_MEOp, addr, din,
    output dout, rsp_valid, addr_err, busy
  );
endinterface

// File: rtl/dm_responder.sv
// dm_responder: data-memory responder at the M stage of the 5-stage pipe.
//   Stores merge bytes into a 2**ADDR_WIDTH x 32 word memory at posedge.
//   Loads are extracted/extended and registered into dout for the W stage.
//   After reset an init FSM writes INIT_VAL to every word (busy=1 meanwhile).
// Ports:
//   clk, rst       : clock, synchronous active-high reset
//   dm (slave)     : DMWr, DMIn_BEOp, DMOut_MEOp, addr, din in;
//                    dout, rsp_valid, addr_err, busy out
// Parameters: ADDR_WIDTH (word-address bits), INIT_VAL (init fill value).
// Optional: define DM_BIG_ENDIAN_EN to mirror byte/halfword lane selection.
module dm_responder #(
  parameter int          ADDR_WIDTH = 10,
  parameter logic [31:0] INIT_VAL   = 32'h0000_0000
) (
  input logic          clk,
  input logic          rst,
  dm_responder_if.slave dm
);
  localparam int DEPTH = 2**ADDR_WIDTH;

  typedef enum logic {S_INIT, S_READY} state_e;

  logic [31:0] mem [DEPTH];

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] init_ptr_q, init_ptr_d;
  logic [31:0]           dout_q, dout_d;
  logic                  rsp_valid_q, rsp_valid_d;
  logic                  addr_err_q, addr_err_d;
  logic                  busy_q, busy_d;

  // access decode
  logic [ADDR_WIDTH-1:0] idx;
  logic [1:0]            lo, bsel;
  logic                  hsel;
  logic                  range_err, st_req, ld_req, st_mis, ld_mis;
  logic [31:0]           rd_word, ld_ext, st_wdata;
  logic [7:0]            rd_byte;
  logic [15:0]           rd_half;
  logic [3:0]            st_be;

  // memory write port
  logic                  mem_we;
  logic [3:0]            mem_be;
  logic [31:0]           mem_wdata;
  logic [ADDR_WIDTH-1:0] mem_widx;

  always_comb begin
    idx       = dm.addr[ADDR_WIDTH+1:2];
    lo        = dm.addr[1:0];
    range_err = |dm.addr[31:ADDR_WIDTH+2];
`ifdef DM_BIG_ENDIAN_EN
    bsel = ~lo;
    hsel = ~lo[1];
`else
    bsel = lo;
    hsel = lo[1];
`endif
    st_req = dm.DMWr && (dm.DMIn_BEOp != 2'd0);
    ld_req = (dm.DMOut_MEOp >= 3'd1) && (dm.DMOut_MEOp <= 3'd5);

    case (dm.DMIn_BEOp)
      2'd1:    st_mis = (lo != 2'd0);
      2'd2:    st_mis = lo[0];
      default: st_mis = 1'b0;
    endcase
    case (dm.DMOut_MEOp)
      3'd1:       ld_mis = (lo != 2'd0);
      3'd2, 3'd3: ld_mis = lo[0];
      default:    ld_mis = 1'b0;
    endcase

    // Stores replicate data across lanes; the byte enables pick the target.
    case (dm.DMIn_BEOp)
      2'd1: begin st_wdata = dm.din;                   st_be = 4'hF; end
      2'd2: begin st_wdata = {2{dm.din[15:0]}};        st_be = hsel ? 4'hC : 4'h3; end
      2'd3: begin st_wdata = {4{dm.din[7:0]}};         st_be = 4'b0001 << bsel; end
      default: begin st_wdata = 32'h0;                 st_be = 4'h0; end
    endcase

    // Async read; a store committed at the previous edge is already visible,
    // which gives write-first behaviour for back-to-back store/load.
    rd_word = mem[idx];
    rd_byte = rd_word[{bsel, 3'b000} +: 8];
    rd_half = rd_word[{hsel, 4'b0000} +: 16];
    case (dm.DMOut_MEOp)
      3'd1:    ld_ext = rd_word;
      3'd2:    ld_ext = {{16{rd_half[15]}}, rd_half};
      3'd3:    ld_ext = {16'h0, rd_half};
      3'd4:    ld_ext = {{24{rd_byte[7]}}, rd_byte};
      3'd5:    ld_ext = {24'h0, rd_byte};
      default: ld_ext = 32'h0;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    init_ptr_d  = init_ptr_q;
    dout_d      = dout_q;
    rsp_valid_d = 1'b0;
    addr_err_d  = 1'b0;
    busy_d      = busy_q;
    mem_we      = 1'b0;
    mem_be      = 4'h0;
    mem_wdata   = 32'h0;
    mem_widx    = idx;
    case (state_q)
      S_INIT: begin
        mem_we     = 1'b1;
        mem_be     = 4'hF;
        mem_wdata  = INIT_VAL;
        mem_widx   = init_ptr_q;
        init_ptr_d = init_ptr_q + ADDR_WIDTH'(1);
        if (&init_ptr_q) begin
          state_d = S_READY;
          busy_d  = 1'b0;
        end
      end
      S_READY: begin
        busy_d = 1'b0;
        if (st_req) begin
          if (range_err || st_mis) begin
            addr_err_d = 1'b1;
          end else begin
            mem_we    = 1'b1;
            mem_be    = st_be;
            mem_wdata = st_wdata;
          end
        end
        // A load issued alongside DMWr is dropped and flagged.
        if (dm.DMWr && ld_req) begin
          addr_err_d = 1'b1;
        end else if (ld_req) begin
          rsp_valid_d = 1'b1;
          if (range_err || ld_mis) begin
            addr_err_d = 1'b1;
            dout_d     = 32'h0;
          end else begin
            dout_d = ld_ext;
          end
        end
      end
      default: state_d = S_INIT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_INIT;
      init_ptr_q  <= '0;
      dout_q      <= 32'h0;
      rsp_valid_q <= 1'b0;
      addr_err_q  <= 1'b0;
      busy_q      <= 1'b1;
    end else begin
      state_q     <= state_d;
      init_ptr_q  <= init_ptr_d;
      dout_q      <= dout_d;
      rsp_valid_q <= rsp_valid_d;
      addr_err_q  <= addr_err_d;
      busy_q      <= busy_d;
    end
  end

  // Storage is not reset directly; the init FSM clears it after reset.
  always_ff @(posedge clk) begin
    if (!rst && mem_we) begin
      for (int n = 0; n < 4; n++) begin
        if (mem_be[n]) mem[mem_widx][8*n +: 8] <= mem_wdata[8*n +: 8];
      end
    end
  end

  assign dm.dout      = dout_q;
  assign dm.rsp_valid = rsp_valid_q;
  assign dm.addr_err  = addr_err_q;
  assign dm.busy      = busy_q;
endmodule
